ifetch_mem_responder: RTL

Memory-side responder for the instruction-fetch block protocol. Accepts a one-cycle block request (enable plus 16-byte-aligned address) from the fetcher and reads 16 consecutive bytes over the byte-wide RAM port. It assembles them little-endian into a 128-bit block and returns it with a one-cycle finish pulse. Sits inside the memory controller, on the fetcher-facing side.

---
 rtl/ifetch_mem_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ifetch_mem_responder.sv
// ---------------------------------------------------------------------------
// ifetch_mem_responder
//
// Memory-side responder for the instruction-fetch block protocol. A one-cycle
// request (enable + block address) starts a sweep of BLOCK_BYTES consecutive
// byte reads over the byte-wide RAM port. Returned bytes are packed
// little-endian into one block, which is handed back with a one-cycle finish
// pulse.
//
// Optional build macro: IFETCH_RESP_LASTBLOCK_EN
//   When defined, the most recently completed block is kept in a one-entry
//   buffer; a request for that same block is answered on the next cycle with
//   no RAM traffic.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rdy                         global ready; low freezes all state/outputs
//   enable_sign_from_fetcher    block request pulse
//   pc_from_fetcher             block address (low offset bits ignored)
//   rollback_sign_from_fetcher  abort the current request
//   mem_grant                   RAM port granted this cycle
//   mem_din                     RAM read data (one cycle after address)
//   mem_a, mem_wr               RAM address / write strobe (always read)
//   busy                        request in progress
//   finish_sign_to_fetcher      one-cycle block-ready pulse
//   inst_block_to_fetcher       assembled block, byte k at bits [8k+7:8k]
// ---------------------------------------------------------------------------
module ifetch_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_BYTES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     enable_sign_from_fetcher,
    input  logic [ADDR_W-1:0]        pc_from_fetcher,
    input  logic                     rollback_sign_from_fetcher,
    input  logic                     mem_grant,
    input  logic [7:0]               mem_din,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    output logic                     busy,
    output logic                     finish_sign_to_fetcher,
    output logic [8*BLOCK_BYTES-1:0] inst_block_to_fetcher
);

    localparam int BLOCK_W = 8 * BLOCK_BYTES;
    localparam int OFF_W   = $clog2(BLOCK_BYTES);
    localparam int CNT_W   = OFF_W + 1;

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_base;
    logic [CNT_W-1:0]     r_issue_idx;
    logic [OFF_W-1:0]     r_cap_idx;
    logic                 r_in_flight;
    logic [BLOCK_W-1:0]   r_buf;
    logic [ADDR_W-1:0]    r_mem_a;
    logic                 r_busy;
    logic                 r_finish;
    logic [BLOCK_W-1:0]   r_block;

    logic [ADDR_W-1:0]    w_req_base;
    logic                 w_issue;
    logic                 w_last_cap;
    logic [CNT_W-1:0]     w_issue_next;
    logic [BLOCK_W-1:0]   w_buf_next;

    // Masking (rather than slicing) keeps every pc bit in use.
    assign w_req_base   = pc_from_fetcher & ~ADDR_W'(BLOCK_BYTES - 1);
    assign w_issue      = mem_grant && (r_issue_idx < CNT_W'(BLOCK_BYTES));
    assign w_last_cap   = r_in_flight && (r_cap_idx == OFF_W'(BLOCK_BYTES - 1));
    assign w_issue_next = r_issue_idx + CNT_W'(1);

    // Buffer with this cycle's byte merged in, so the completing edge can
    // publish the whole block including the final byte.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_buf_next unassigned (no latch).
        w_buf_next = r_buf;
        if (r_in_flight)
            w_buf_next[8*r_cap_idx +: 8] = mem_din;
    end

`ifdef IFETCH_RESP_LASTBLOCK_EN
    logic                 r_lb_valid;
    logic [ADDR_W-1:0]    r_lb_addr;
    logic [BLOCK_W-1:0]   r_lb_block;
    logic                 w_lb_hit;

    assign w_lb_hit = r_lb_valid && (r_lb_addr == w_req_base);

    // Loaded only by a completed read; rollback never touches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lb_valid <= 1'b0;
        end else if (rdy && !rollback_sign_from_fetcher
                     && r_state == S_READ && w_last_cap) begin
            r_lb_valid <= 1'b1;
            r_lb_addr  <= r_base;
            r_lb_block <= w_buf_next;
        end
    end
`endif

    // NOTE: the assembly buffer has no reset; every byte is rewritten before it is published.
    always_ff @(posedge clk) begin
        if (!rst && rdy && r_state == S_READ)
            r_buf <= w_buf_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_issue_idx <= '0;
            r_cap_idx   <= '0;
            r_in_flight <= 1'b0;
            r_mem_a     <= '0;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
            r_block     <= '0;
        end else if (rdy) begin
            r_finish <= 1'b0;
            if (rollback_sign_from_fetcher) begin
                // Drop the partial block and any byte still on its way.
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_in_flight <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (enable_sign_from_fetcher) begin
                            r_base      <= w_req_base;
                            r_issue_idx <= '0;
                            r_cap_idx   <= '0;
                            r_in_flight <= 1'b0;
`ifdef IFETCH_RESP_LASTBLOCK_EN
                            if (w_lb_hit) begin
                                r_finish <= 1'b1;
                                r_block  <= r_lb_block;
                            end else begin
                                r_mem_a <= w_req_base;
                                r_busy  <= 1'b1;
                                r_state <= S_READ;
                            end
`else
                            r_mem_a <= w_req_base;
                            r_busy  <= 1'b1;
                            r_state <= S_READ;
`endif
                        end
                    end

                    S_READ: begin
                        // A denied grant means the address was not taken,
                        // so nothing returns next cycle.
                        r_in_flight <= w_issue;
                        if (w_issue) begin
                            r_issue_idx <= w_issue_next;
                            r_mem_a     <= r_base + ADDR_W'(w_issue_next);
                        end
                        if (r_in_flight) begin
                            r_cap_idx <= r_cap_idx + OFF_W'(1);
                            if (w_last_cap) begin
                                r_block  <= w_buf_next;
                                r_finish <= 1'b1;
                                r_busy   <= 1'b0;
                                r_state  <= S_IDLE;
                            end
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign mem_a                  = r_mem_a;
    assign mem_wr                 = 1'b0;
    assign busy                   = r_busy;
    assign finish_sign_to_fetcher = r_finish;
    assign inst_block_to_fetcher  = r_block;

endmodule
